// File: rtl/seg_pkg.sv
// ============================================================================
// seg_pkg : shared constants for the eight-digit seven-segment scanner
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int PRESCALE_W = 24;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low patterns, bit order seg[6:0] = {CG,CF,CE,CD,CC,CB,CA}
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

`default_nettype wire

// File: rtl/hex_to_seg.sv
// ============================================================================
// hex_to_seg : combinational hex nibble to active-low seven-segment pattern
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

`default_nettype wire

// File: rtl/seven_seg_scan.sv
// ============================================================================
// seven_seg_scan : time-multiplexed 8-digit hex display driver with a
//                  frame-synchronous shadow register (no tearing).
//                  Option macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module seven_seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam logic [PRESCALE_W-1:0] DIV_LAST  = PRESCALE_W'(CLK_DIV - 1);
  localparam logic [2:0]            LAST_SLOT = 3'(NUM_DIGITS - 1);

  logic [PRESCALE_W-1:0]   prescale;
  logic [2:0]              idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    tick;
  logic                    frame_end;
  logic [3:0]              nibble;
  logic [6:0]              digit_seg;
  logic                    blank;

  assign tick      = (prescale == DIV_LAST);
  assign frame_end = tick && (idx == LAST_SLOT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale   <= '0;
      idx        <= '0;
      shadow     <= '0;
      frame_done <= 1'b0;
    end else begin
      prescale   <= tick ? '0 : prescale + PRESCALE_W'(1);
      if (tick) begin
        idx <= idx + 3'd1;
      end
      // Display data is only sampled at the frame seam so a frame never tears
      if (frame_end) begin
        shadow <= data_in;
      end
      frame_done <= frame_end;
    end
  end

  assign nibble = shadow[{idx, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (digit_seg)
  );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [2:0] msd;

  // Digit 0 is never blanked, so msd starts at 0
  always_comb begin
    msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (shadow[4*k +: 4] != 4'h0) begin
        msd = 3'(k);
      end
    end
  end

  assign blank = (idx > msd);
`else
  assign blank = 1'b0;
`endif

  assign an  = blank ? '1 : ~(NUM_DIGITS'(1) << idx);
  assign seg = blank ? SEG_BLANK : digit_seg;
  assign dp  = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
// ============================================================================
// tb_seven_seg_scan : randomized self-checking bench for seven_seg_scan
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  localparam logic [6:0] EXP_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst;
  logic [31:0] data_in = 32'h0;
  logic [7:0]  an, an1;
  logic [6:0]  seg, seg1;
  logic        dp, dp1, fd, fd1;

  int checks = 0;
  int errors = 0;
  int t = 0;
  int cyc = 0;
  int last_fd = -1;
  int last_fd1 = -1;
  logic [31:0] shown = 32'h0;

  seven_seg_scan #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .data_in(data_in),
    .an(an), .seg(seg), .dp(dp), .frame_done(fd)
  );

  seven_seg_scan #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in),
    .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: slot position and displayed value follow from elapsed cycles alone
  task automatic expected_out(output logic [7:0] e_an, output logic [6:0] e_seg, output logic e_fd);
    int  idx;
    int  nib;
    bit  blank;
    idx   = (t / DIV) % 8;
    nib   = int'((shown >> (4 * idx)) & 32'hF);
    blank = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    begin
      int msd;
      msd = 0;
      for (int k = 0; k < 8; k++)
        if (((shown >> (4 * k)) & 32'hF) != 0) msd = k;
      blank = (idx > msd);
    end
`endif
    e_an  = blank ? 8'hFF : (8'hFF ^ (8'h01 << idx));
    e_seg = blank ? 7'h7F : EXP_HEX[nib];
    e_fd  = (t > 0) && (t % FRAME == 0);
  endtask

  task automatic model_reset();
    t        = 0;
    shown    = 32'h0;
    last_fd  = -1;
    last_fd1 = -1;
  endtask

  task automatic cycle_check();
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_fd;
    @(posedge clk);
    cyc++;
    if (rst) begin
      t++;
      if (t % FRAME == 0) shown = data_in;
    end
    @(negedge clk);
    expected_out(e_an, e_seg, e_fd);
    check_value("an", 32'(an), 32'(e_an));
    check_value("seg", 32'(seg), 32'(e_seg));
    check_value("dp", 32'(dp), 32'h1);
    check_value("frame_done", 32'(fd), 32'(e_fd));
    if (fd) begin
      if (last_fd >= 0) check_value("fd_period_div4", 32'(cyc - last_fd), 32'(FRAME));
      last_fd = cyc;
    end
    if (fd1) begin
      if (last_fd1 >= 0) check_value("fd_period_div1", 32'(cyc - last_fd1), 32'd8);
      last_fd1 = cyc;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle_check();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check_value("rst_noclk_an", 32'(an), 32'hFE);
    check_value("rst_noclk_seg", 32'(seg), 32'h40);
    check_value("rst_noclk_dp", 32'(dp), 32'h1);
    check_value("rst_noclk_fd", 32'(fd), 32'h0);
    model_reset();
    clk_run = 1'b1;
    run_cycles(2);

    rst     = 1'b1;
    data_in = 32'h12345678;
    run_cycles(FRAME);
    n = 0;
    while (!(t >= FRAME && ((t / DIV) % 8) == 3) && n < 200) begin
      cycle_check();
      n++;
    end
    data_in = 32'hDEADBEEF;
    run_cycles(2 * FRAME + 4);

    n = 0;
    while (!(((t / DIV) % 8) == 5 && (t % DIV) == 1) && n < 200) begin
      cycle_check();
      n++;
    end
    #2 rst = 1'b0;
    #1;
    check_value("rst_async_an", 32'(an), 32'hFE);
    check_value("rst_async_seg", 32'(seg), 32'h40);
    check_value("rst_async_fd", 32'(fd), 32'h0);
    model_reset();
    run_cycles(2);
    rst = 1'b1;
    n = 0;
    do begin
      cycle_check();
      n++;
    end while (!fd && n < 100);
    check_value("rst_release_to_fd", 32'(n), 32'(FRAME));

    data_in = 32'h000000A5;
    run_cycles(2 * FRAME);
    data_in = 32'h0;
    run_cycles(2 * FRAME);

    for (int i = 0; i < 30 * FRAME; i++) begin
      cycle_check();
      if ($urandom_range(0, 5) == 0)
        data_in = $urandom >> (4 * $urandom_range(0, 8));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
